// File: rtl/fpu_cvt_pkg.sv
// Shared definitions for the FP32->integer conversion scheduler.
package fpu_cvt_pkg;

  localparam int FP_W     = 32;
  localparam int NREQ_DEF = 4;

  // Scheduler state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_RESP = ST_RESP
  } cvt_state_t;

  // Ceiling log2; used to size requester IDs and the latency counter
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cvt_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module cvt_rr_arbiter
  import fpu_cvt_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);

  // Search rr_ptr, rr_ptr+1, ... (mod NREQ) for the first valid request
  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    if (enable) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!any_grant && req[(int'(rr_ptr) + k) % NREQ]) begin
          any_grant = 1'b1;
          grant_idx = IDW'((int'(rr_ptr) + k) % NREQ);
        end
      end
    end
  end

  // One-hot expansion of the winning index
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign grant[gi] = any_grant && (grant_idx == IDW'(gi));
    end
  endgenerate

endmodule

// File: rtl/fpu_cvt_scheduler.sv
// Shares one external fixed-latency FP32->int converter between NREQ requesters.
// Round-robin accept in IDLE, operand held for CVT_LAT cycles in BUSY,
// result returned with the owner ID in RESP under response backpressure.
module fpu_cvt_scheduler
  import fpu_cvt_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int CVT_LAT = 1,
  parameter int IDW     = clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_operand,
  output logic [NREQ-1:0]      req_ready,
  output logic                 cvt_valid,
  output logic [FP_W-1:0]      cvt_operand,
  input  logic [FP_W-1:0]      cvt_result,
  output logic                 resp_valid,
  output logic [FP_W-1:0]      resp_data,
  output logic [IDW-1:0]       resp_id,
  input  logic                 resp_ready,
  output logic                 busy
);

  // Latency counter only has to hold CVT_LAT-1
  localparam int LCW = (CVT_LAT > 1) ? clog2(CVT_LAT) : 1;

  cvt_state_t        state_reg;
  cvt_state_t        state_next;
  logic [IDW-1:0]    rr_ptr_reg;
  logic [LCW-1:0]    lat_cnt_reg;
  logic [FP_W-1:0]   op_reg;
  logic [FP_W-1:0]   res_reg;
  logic [IDW-1:0]    id_reg;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              any_grant;
  logic              arb_enable;
  logic [FP_W-1:0]   operand_arr [NREQ];

  // Unpack the flat operand bus into per-requester words
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign operand_arr[gi] = req_operand[gi*FP_W +: FP_W];
    end
  endgenerate

  // Arbitration only runs in IDLE and never while reset is held
  assign arb_enable = (state_reg == S_IDLE) && !RESET;

  cvt_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .enable    (arb_enable),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and state-derived outputs; outputs are zero outside
  // their owning state so the converter never sees a stale operand as valid
  always_comb begin
    state_next  = state_reg;
    req_ready   = '0;
    cvt_valid   = 1'b0;
    cvt_operand = '0;
    resp_valid  = 1'b0;
    resp_data   = '0;
    resp_id     = '0;
    busy        = (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE: begin
        req_ready = grant;
        if (any_grant) state_next = S_BUSY;
      end
      S_BUSY: begin
        cvt_valid   = 1'b1;
        cvt_operand = op_reg;
        if (lat_cnt_reg == '0) state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_data  = res_reg;
        resp_id    = id_reg;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: capture the granted request, count latency, sample the result
  // only on the last BUSY cycle so X on cvt_result elsewhere is ignored
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr_reg  <= '0;
      lat_cnt_reg <= '0;
      op_reg      <= '0;
      res_reg     <= '0;
      id_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (any_grant) begin
            op_reg      <= operand_arr[grant_idx];
            id_reg      <= grant_idx;
            lat_cnt_reg <= LCW'(CVT_LAT - 1);
            if (int'(grant_idx) == NREQ - 1) rr_ptr_reg <= '0;
            else                             rr_ptr_reg <= grant_idx + IDW'(1);
          end
        end
        S_BUSY: begin
          if (lat_cnt_reg != '0) lat_cnt_reg <= lat_cnt_reg - LCW'(1);
          else                   res_reg     <= cvt_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_cvt_scheduler.sv
// Self-checking bench: two schedulers (CVT_LAT=1 and CVT_LAT=3) checked every
// cycle against a transaction-timing reference model, plus directed checks.
module tb_fpu_cvt_scheduler;

  localparam logic [31:0] MASK = 32'hFFFF_0000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]   req_valid   [2];
  logic [127:0] req_operand [2];
  logic [3:0]   req_ready   [2];
  logic         cvt_valid   [2];
  logic [31:0]  cvt_operand [2];
  logic [31:0]  cvt_result  [2];
  logic         resp_valid  [2];
  logic [31:0]  resp_data   [2];
  logic [1:0]   resp_id     [2];
  logic         resp_ready  [2];
  logic         busy        [2];

  always #5 CLK = ~CLK;

  // Instance 0 uses CVT_LAT=1, instance 1 uses CVT_LAT=3; each has a converter stub
  generate
    for (genvar gk = 0; gk < 2; gk++) begin : g_dut
      fpu_cvt_scheduler #(
        .NREQ    (4),
        .CVT_LAT ((gk == 0) ? 1 : 3),
        .IDW     (2)
      ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req_valid   (req_valid[gk]),
        .req_operand (req_operand[gk]),
        .req_ready   (req_ready[gk]),
        .cvt_valid   (cvt_valid[gk]),
        .cvt_operand (cvt_operand[gk]),
        .cvt_result  (cvt_result[gk]),
        .resp_valid  (resp_valid[gk]),
        .resp_data   (resp_data[gk]),
        .resp_id     (resp_id[gk]),
        .resp_ready  (resp_ready[gk]),
        .busy        (busy[gk])
      );
      assign cvt_result[gk] = cvt_valid[gk] ? (cvt_operand[gk] ^ MASK) : 32'hxxxx_xxxx;
    end
  endgenerate

  // Reference model: a transaction accepted at cycle A is in BUSY for
  // A+1..A+LAT and presents its response from A+LAT+1 until the handshake.
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          acc [2];
  int          ptr [2];
  int          mid [2];
  int          lat [2];
  logic [31:0] mop [2];
  int          gq0 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k);
    int          g;
    bit          any;
    int          d;
    bit          idle, inbusy, inresp;
    logic [3:0]  er;
    string       t;
    t = $sformatf("d%0d_c%0d", k, cyc);
    if (k == 0 && (req_ready[0] & req_valid[0]) != 4'b0)
      for (int i = 0; i < 4; i++) if (req_ready[0][i]) gq0.push_back(i);
    if (RESET) begin
      chk({t, "_rst_ready"}, 32'(req_ready[k]), 32'h0);
      acc[k] = -1;
      ptr[k] = 0;
      return;
    end
    any = 1'b0;
    g   = 0;
    for (int j = 0; j < 4; j++) begin
      int i;
      i = (ptr[k] + j) % 4;
      if (!any && req_valid[k][i]) begin
        any = 1'b1;
        g   = i;
      end
    end
    d      = cyc - acc[k];
    idle   = (acc[k] < 0);
    inbusy = !idle && (d <= lat[k]);
    inresp = !idle && (d > lat[k]);
    er     = (idle && any) ? (4'b0001 << g) : 4'b0000;
    chk({t, "_req_ready"},   32'(req_ready[k]),  32'(er));
    chk({t, "_cvt_valid"},   32'(cvt_valid[k]),  32'(inbusy));
    chk({t, "_cvt_operand"}, cvt_operand[k],     inbusy ? mop[k] : 32'h0);
    chk({t, "_resp_valid"},  32'(resp_valid[k]), 32'(inresp));
    chk({t, "_resp_data"},   resp_data[k],       inresp ? (mop[k] ^ MASK) : 32'h0);
    chk({t, "_resp_id"},     32'(resp_id[k]),    inresp ? 32'(mid[k]) : 32'h0);
    chk({t, "_busy"},        32'(busy[k]),       32'(!idle));
    if (idle && any) begin
      acc[k] = cyc;
      mop[k] = req_operand[k][32*g +: 32];
      mid[k] = g;
      ptr[k] = (g + 1) % 4;
    end else if (inresp && resp_ready[k]) begin
      acc[k] = -1;
    end
  endtask

  // One clock: check both instances mid-cycle, then advance past the next edge
  task automatic cycle();
    #4;
    check_dut(0);
    check_dut(1);
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    RESET = 1'b0;
  endtask

  initial begin
    int exp_order [5];
    int cnt;
    int pos;
    exp_order = '{0, 1, 2, 3, 0};
    lat = '{1, 3};
    for (int k = 0; k < 2; k++) begin
      acc[k] = -1; ptr[k] = 0; mid[k] = 0; mop[k] = '0;
      req_valid[k] = '0; req_operand[k] = '0; resp_ready[k] = 1'b1;
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    do_reset(2);

    // Single request from requester 1
    req_valid[0] = 4'b0010;
    req_operand[0][63:32] = 32'h40A0_0000;
    cycle();
    req_valid[0] = 4'b0000;
    cycle();
    chk("t1_resp_valid", 32'(resp_valid[0]), 32'h1);
    chk("t1_resp_data",  resp_data[0], 32'hBF5F_0000);
    chk("t1_resp_id",    32'(resp_id[0]), 32'h1);
    cycle();
    cycle();

    // All four requesters valid continuously
    do_reset(1);
    gq0.delete();
    for (int i = 0; i < 4; i++) req_operand[0][32*i +: 32] = $urandom;
    req_valid[0] = 4'b1111;
    for (int i = 0; i < 15; i++) cycle();
    chk("t2_grant_count", 32'(gq0.size() >= 5), 32'h1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_grant%0d", i), (i < gq0.size()) ? 32'(gq0[i]) : 32'hFFFF_FFFF,
          32'(exp_order[i]));

    // Response backpressure for 5 cycles
    do_reset(1);
    resp_ready[0] = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    resp_ready[0] = 1'b1;
    cycle();
    chk("t3_resume", 32'(req_ready[0] != 4'b0), 32'h1);
    cycle();

    // CVT_LAT=3 instance: converter driven for exactly three cycles
    req_valid[1] = 4'b0100;
    req_operand[1][95:64] = 32'h3F80_0000;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (cvt_valid[1]) cnt++;
      cycle();
      req_valid[1] = 4'b0000;
    end
    chk("t4_cvt_cycles", 32'(cnt), 32'd3);

    // Reset during BUSY discards the transaction and clears the pointer
    req_valid[1] = 4'b0001;
    req_operand[1][31:0] = 32'h1234_5678;
    cycle();
    req_valid[1] = 4'b0000;
    cycle();
    do_reset(1);
    chk("t5_busy",       32'(busy[1]), 32'h0);
    chk("t5_resp_valid", 32'(resp_valid[1]), 32'h0);
    chk("t5_cvt_valid",  32'(cvt_valid[1]), 32'h0);
    req_valid[1] = 4'b0101;
    #1;
    chk("t5_grant0_first", 32'(req_ready[1]), 32'h1);
    cycle();
    req_valid[1] = 4'b0100;
    for (int i = 0; i < 6; i++) cycle();
    req_valid[1] = 4'b0000;

    // Requester 3 raised once against a permanently valid requester 0
    gq0.delete();
    req_valid[0] = 4'b1001;
    for (int i = 0; i < 14; i++) begin
      cycle();
      foreach (gq0[j]) if (gq0[j] == 3) req_valid[0][3] = 1'b0;
    end
    pos = -1;
    foreach (gq0[j]) if (gq0[j] == 3 && pos < 0) pos = j;
    chk("t6_no_starve", 32'(pos >= 0 && pos < 4), 32'h1);
    req_valid[0] = 4'b0000;

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = 4'($urandom_range(0, 15));
        for (int r = 0; r < 4; r++) req_operand[k][32*r +: 32] = $urandom;
        resp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      RESET = ($urandom_range(0, 99) == 0);
      cycle();
    end
    RESET = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
